plane_transpose: RTL and testbench

//  Converts per-channel duty words from the SPI path into bit-plane writes
//  for the PWM register file. Sits between spi_slave and mux, in place of

---
 rtl/plane_transpose_if.sv | 30 +++
 rtl/plane_transpose.sv | 203 ++++++++++++++++++++
 tb/tb_plane_transpose.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/plane_transpose_if.sv
// Bus bundle for plane_transpose: the duty-word input stream plus the
// bit-plane write port toward the PWM register file.
// slave  = transposer view, master = producer / register-file view.
interface plane_transpose_if #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 12
);
    localparam int addr_w = $clog2(pwm_width);

    logic                 frame_start;
    logic                 in_valid;
    logic [pwm_width-1:0] in_data;
    logic                 in_ready;
    logic [addr_w-1:0]    write_addr;
    logic [num_pwm-1:0]   write_data;
    logic                 write_enable;
    logic                 write_done;
    logic                 frame_done;
    logic                 busy;

    modport slave (
        input  frame_start, in_valid, in_data, write_done,
        output in_ready, write_addr, write_data, write_enable, frame_done, busy
    );

    modport master (
        output frame_start, in_valid, in_data, write_done,
        input  in_ready, write_addr, write_data, write_enable, frame_done, busy
    );
endinterface

// File: rtl/plane_transpose.sv
// plane_transpose: gathers one duty word per channel, then emits one write per
// bit plane, where plane k carries bit k of every channel.
// Optional feature macro: PLANE_TRANSPOSE_DBUF_EN (ping-pong duty banks so the
// next frame can be collected while the current one is transposed).

// One channel's duty storage. bit_out looks ahead through this cycle's write
// so the registered plane word can be formed on the same edge that stores
// the last duty word of a frame.
module plane_transpose_lane #(
    parameter int width  = 16,
    parameter int addr_w = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
`ifdef PLANE_TRANSPOSE_DBUF_EN
    input  logic              wsel,
    input  logic              rsel,
`endif
    input  logic [width-1:0]  wdata,
    input  logic [addr_w-1:0] rk,
    output logic              bit_out
);
`ifdef PLANE_TRANSPOSE_DBUF_EN
    logic [1:0][width-1:0] word, word_n;

    // bank storage, written only on an accepted word for this channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    word       <= '0;
        else if (we) word[wsel] <= wdata;
    end

    // post-write view of the banks, then select the bit for the next plane
    always_comb begin
        word_n = word;
        if (we) word_n[wsel] = wdata;
        bit_out = word_n[rsel][rk];
    end
`else
    logic [width-1:0] word, word_n;

    // single duty word, written only on an accepted word for this channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    word <= '0;
        else if (we) word <= wdata;
    end

    // post-write view, then select the bit for the next plane
    always_comb begin
        word_n = we ? wdata : word;
        bit_out = word_n[rk];
    end
`endif
endmodule

module plane_transpose #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 12
) (
    input  logic              clk,
    input  logic              rst,
    plane_transpose_if.slave  bus
);
    localparam int addr_w = $clog2(pwm_width);
    localparam int ch_w   = (num_pwm > 1) ? $clog2(num_pwm) : 1;

    typedef enum logic {COLLECT, XPOSE} state_t;

    state_t              state, state_n;
    logic [ch_w-1:0]     ch_idx, ch_idx_n, eff_idx;
    logic [addr_w-1:0]   k, k_n;
    logic                wr_en, wr_en_n, done_pulse, done_pulse_n;
    logic [num_pwm-1:0]  wr_data, wr_data_n, plane_bits;
    logic                fill_active, accept, last;

`ifdef PLANE_TRANSPOSE_DBUF_EN
    logic fill_sel, fill_sel_n, rd_sel, rd_sel_n, pending, pending_n;
    // the fill bank takes words unless it holds a complete frame still waiting
    assign fill_active = !pending;
`else
    assign fill_active = (state == COLLECT);
`endif

    // frame_start rebases this cycle's word to channel 0
    assign eff_idx = bus.frame_start ? '0 : ch_idx;
    assign accept  = bus.in_valid && fill_active;
    assign last    = accept && (eff_idx == ch_w'(num_pwm - 1));

    // per-channel duty storage
    for (genvar i = 0; i < num_pwm; i++) begin : g_lane
        plane_transpose_lane #(.width(pwm_width), .addr_w(addr_w)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (accept && (eff_idx == ch_w'(i))),
`ifdef PLANE_TRANSPOSE_DBUF_EN
            .wsel    (fill_sel),
            .rsel    (rd_sel_n),
`endif
            .wdata   (bus.in_data),
            .rk      (k_n),
            .bit_out (plane_bits[i])
        );
    end

    // next-state: channel index, plane counter, write request, bank control
    always_comb begin
        state_n      = state;
        k_n          = k;
        wr_en_n      = wr_en;
        done_pulse_n = 1'b0;
`ifdef PLANE_TRANSPOSE_DBUF_EN
        fill_sel_n   = fill_sel;
        rd_sel_n     = rd_sel;
        pending_n    = pending;
`endif
        if (accept)                           ch_idx_n = last ? '0 : eff_idx + ch_w'(1);
        else if (bus.frame_start && fill_active) ch_idx_n = '0;
        else                                  ch_idx_n = ch_idx;

        case (state)
            COLLECT: begin
`ifdef PLANE_TRANSPOSE_DBUF_EN
                if (pending || last) begin
                    pending_n  = 1'b0;
                    rd_sel_n   = fill_sel;
                    fill_sel_n = ~fill_sel;
                    state_n    = XPOSE;
                    k_n        = '0;
                    wr_en_n    = 1'b1;
                end
`else
                if (last) begin
                    state_n = XPOSE;
                    k_n     = '0;
                    wr_en_n = 1'b1;
                end
`endif
            end
            XPOSE: begin
`ifdef PLANE_TRANSPOSE_DBUF_EN
                if (last) pending_n = 1'b1;
`endif
                if (bus.write_done) begin
                    if (k == addr_w'(pwm_width - 1)) begin
                        state_n      = COLLECT;
                        k_n          = '0;
                        wr_en_n      = 1'b0;
                        done_pulse_n = 1'b1;
                    end else begin
                        k_n = k + addr_w'(1);
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // plane word for the next cycle; zero whenever no write is pending
    always_comb begin
        wr_data_n = wr_en_n ? plane_bits : '0;
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            ch_idx     <= '0;
            k          <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            ch_idx     <= ch_idx_n;
            k          <= k_n;
            wr_en      <= wr_en_n;
            wr_data    <= wr_data_n;
            done_pulse <= done_pulse_n;
        end
    end

`ifdef PLANE_TRANSPOSE_DBUF_EN
    // bank selects and the "fill bank complete" flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_sel <= 1'b0;
            rd_sel   <= 1'b0;
            pending  <= 1'b0;
        end else begin
            fill_sel <= fill_sel_n;
            rd_sel   <= rd_sel_n;
            pending  <= pending_n;
        end
    end
`endif

    assign bus.in_ready     = fill_active;
    assign bus.write_enable = wr_en;
    assign bus.write_addr   = k;
    assign bus.write_data   = wr_data;
    assign bus.frame_done   = done_pulse;
    assign bus.busy         = (state == XPOSE);
endmodule

// File: tb/tb_plane_transpose.sv
// Bench for plane_transpose: directed steps plus random frames, each plane
// write compared with planes built from the frame's duty words.
module tb_plane_transpose;
    localparam int W = 16;
    localparam int N = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    plane_transpose_if #(.pwm_width(W), .num_pwm(N)) bus ();
    plane_transpose #(.pwm_width(W), .num_pwm(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [W-1:0] fa [N];
    logic [W-1:0] fb [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [W-1:0] w, input bit fs);
        @(negedge clk);
        chk("in_ready_feed", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_data = w; bus.frame_start = fs;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.frame_start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] f [N]);
        for (int c = 0; c < N; c++) feed(f[c], 1'b0);
    endtask

    // expected plane k: bit c is bit k of channel c's duty word
    function automatic logic [N-1:0] plane(input logic [W-1:0] f [N], input int kk);
        logic [N-1:0] p;
        for (int c = 0; c < N; c++) p[c] = f[c][kk];
        return p;
    endfunction

    task automatic xpose(input logic [W-1:0] f [N], input int stall_k, input int stall_n,
                         input bit chain, input bit junk);
        for (int kk = 0; kk < W; kk++) begin
            @(negedge clk);
            chk("we", bus.write_enable, 1);
            chk("addr", bus.write_addr, kk);
            chk("data", bus.write_data, plane(f, kk));
            chk("busy", bus.busy, 1);
`ifndef PLANE_TRANSPOSE_DBUF_EN
            chk("in_ready_xpose", bus.in_ready, 0);
            bus.in_valid = junk; bus.frame_start = junk; bus.in_data = W'($urandom);
`endif
            if (kk == stall_k) begin
                bus.write_done = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_we", bus.write_enable, 1);
                    chk("stall_addr", bus.write_addr, kk);
                    chk("stall_data", bus.write_data, plane(f, kk));
                end
            end
            bus.write_done = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.frame_start = 1'b0;
        chk("frame_done", bus.frame_done, 1);
        chk("we_after", bus.write_enable, 0);
        chk("busy_after", bus.busy, 0);
        bus.write_done = 1'b0;
        if (!chain) begin
            @(negedge clk);
            chk("frame_done_pulse", bus.frame_done, 0);
            chk("in_ready_after", bus.in_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.frame_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.write_done = 1'b0;

        // reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_we", bus.write_enable, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_we_rel", bus.write_enable, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.write_data, 0);
        chk("rst_addr", bus.write_addr, 0);

        // basic frame: one-hot per channel; input traffic during transpose ignored
        for (int c = 0; c < N; c++) fa[c] = W'(1) << c;
        send(fa);
        xpose(fa, -1, 0, 1'b0, 1'b1);

        // stall at plane 3
        for (int c = 0; c < N; c++) fa[c] = 16'hA5A5;
        send(fa);
        xpose(fa, 3, 5, 1'b0, 1'b0);

        // resync: partial frame discarded by frame_start
        for (int c = 0; c < 5; c++) feed(W'($urandom), 1'b0);
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        for (int c = 0; c < N; c++) fa[c] = 16'hFFFF;
        send(fa);
        xpose(fa, -1, 0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_write", bus.write_enable, 0);
        end

        // async reset mid-transpose at plane 7
        for (int c = 0; c < N; c++) fa[c] = W'($urandom);
        send(fa);
        bus.write_done = 1'b1;
        for (int kk = 0; kk < 8; kk++) begin
            @(negedge clk);
            chk("pre_rst_addr", bus.write_addr, kk);
            chk("pre_rst_data", bus.write_data, plane(fa, kk));
        end
        bus.write_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_we", bus.write_enable, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_frame_done", bus.frame_done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_hold_fd", bus.frame_done, 0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("arst_rel_ready", bus.in_ready, 1);
            chk("arst_rel_we", bus.write_enable, 0);
            chk("arst_rel_fd", bus.frame_done, 0);
        end

        // random frames: random partial prefix, then frame_start with word 0
        for (int r = 0; r < 4; r++) begin
            int pre;
            pre = $urandom_range(0, N - 1);
            for (int c = 0; c < pre; c++) feed(W'($urandom), 1'b0);
            for (int c = 0; c < N; c++) fa[c] = W'($urandom);
            feed(fa[0], 1'b1);
            for (int c = 1; c < N; c++) feed(fa[c], 1'b0);
            xpose(fa, $urandom_range(0, W - 1), $urandom_range(1, 4), 1'b0, 1'b1);
        end

`ifdef PLANE_TRANSPOSE_DBUF_EN
        // second frame collected while the first is stalled in transpose
        for (int c = 0; c < N; c++) begin fa[c] = W'($urandom); fb[c] = W'($urandom); end
        send(fa);
        send(fb);
        @(negedge clk);
        chk("dbuf_full_ready", bus.in_ready, 0);
        chk("dbuf_stall_addr", bus.write_addr, 0);
        xpose(fa, -1, 0, 1'b1, 1'b0);
        xpose(fb, -1, 0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
